pipe_stage_skid: RTL

//   Parametrised inter-stage pipeline register (IF/ID, ID/EX, ...) with valid/ready handshake.

---
 rtl/pipe_stage_skid_pkg.sv | 16 +
 rtl/pipe_stage_skid_sat_counter.sv | 19 +
 rtl/pipe_stage_skid.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared constants and state encoding for the skid-buffered pipeline register.
package pipe_stage_skid_pkg;

  localparam int unsigned INST_ADDR_BUS_W = 32;
  localparam int unsigned INST_BUS_W      = 32;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic FLUSH_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } skid_state_t;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register: main + skid slot, registered up_ready, synchronous flush
// and a saturating back-pressure counter.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned PC_W     = INST_ADDR_BUS_W,
  parameter int unsigned DATA_W   = INST_BUS_W,
  parameter int unsigned CNT_W    = 16,
  parameter bit          ZERO_BUB = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [PC_W-1:0]   up_pc,
  input  logic [DATA_W-1:0] up_inst,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [PC_W-1:0]   dn_pc,
  output logic [DATA_W-1:0] dn_inst,
  output logic [CNT_W-1:0]  stall_cnt
);

  skid_state_t       state;
  logic              rst_act;
  logic              flush_act;
  logic              up_fire;
  logic              dn_fire;
  logic              up_ready_q;
  logic              dn_valid_q;
  logic [PC_W-1:0]   main_pc;
  logic [DATA_W-1:0] main_inst;
  logic [PC_W-1:0]   skid_pc;
  logic [DATA_W-1:0] skid_inst;

  assign rst_act   = (rst == RST_ENABLE);
  assign flush_act = (flush == FLUSH_ENABLE);
  assign up_fire   = up_valid & up_ready_q;
  assign dn_fire   = dn_valid_q & dn_ready;

  // up_ready/dn_valid are registered alongside the state so neither has a
  // combinational path from the handshake inputs.
  always_ff @(posedge clk) begin
    if (rst_act) begin
      state      <= EMPTY;
      up_ready_q <= 1'b1;
      dn_valid_q <= 1'b0;
      main_pc    <= '0;
      main_inst  <= '0;
      skid_pc    <= '0;
      skid_inst  <= '0;
    end else if (flush_act) begin
      state      <= EMPTY;
      up_ready_q <= 1'b1;
      dn_valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (up_fire) begin
            state      <= ONE;
            dn_valid_q <= 1'b1;
            main_pc    <= up_pc;
            main_inst  <= up_inst;
          end
        end
        ONE: begin
          if (up_fire && !dn_fire) begin
            state      <= TWO;
            up_ready_q <= 1'b0;
            skid_pc    <= up_pc;
            skid_inst  <= up_inst;
          end else if (up_fire && dn_fire) begin
            main_pc   <= up_pc;
            main_inst <= up_inst;
          end else if (dn_fire) begin
            state      <= EMPTY;
            dn_valid_q <= 1'b0;
          end
        end
        TWO: begin
          if (dn_fire) begin
            state      <= ONE;
            up_ready_q <= 1'b1;
            main_pc    <= skid_pc;
            main_inst  <= skid_inst;
          end
        end
        default: begin
          state      <= EMPTY;
          up_ready_q <= 1'b1;
          dn_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign up_ready = up_ready_q;
  assign dn_valid = dn_valid_q;

  generate
    if (ZERO_BUB) begin : g_zero_bubble
      assign dn_pc   = dn_valid_q ? main_pc   : '0;
      assign dn_inst = dn_valid_q ? main_inst : '0;
    end else begin : g_hold_bubble
      assign dn_pc   = main_pc;
      assign dn_inst = main_inst;
    end
  endgenerate

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .clr (rst_act),
    .inc (dn_valid_q & ~dn_ready),
    .cnt (stall_cnt)
  );

endmodule
